// File: rtl/bitslip_train.sv
// Bitslip training FSM: sweeps slip counts 0..7 until the frame lane shows the
// expected pattern for MATCH_CYCLES consecutive words. It then holds lock or, after MAX_PASSES sweeps, reports failure.
module bitslip_train #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_CYCLES  = 16,
  parameter int unsigned MAX_PASSES    = 2
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [7:0] frame_data,
  output logic [3:0] bitslip_count,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic       lock_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_NEXT,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CYCLES - 1);
  localparam logic [3:0] PASS_LIMIT  = 4'(MAX_PASSES);
  localparam logic [3:0] SLIP_LAST   = 4'd7;

  state_t     state, state_n;
  logic [7:0] settle_cnt, settle_cnt_n;
  logic [7:0] match_cnt, match_cnt_n;
  logic [3:0] pass_cnt, pass_cnt_n;
  logic [3:0] slip_n;
  logic       busy_n, locked_n, fail_n, lock_err_n;
  logic       word_ok;
  logic       restart;

  assign word_ok = (frame_data == pattern);
  assign restart = start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL);

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    match_cnt_n  = match_cnt;
    pass_cnt_n   = pass_cnt;
    slip_n       = bitslip_count;
    busy_n       = busy;
    locked_n     = locked;
    fail_n       = fail;
    lock_err_n   = lock_err;

    case (state)
      S_SETTLE: begin
        settle_cnt_n = settle_cnt - 8'd1;
        if (settle_cnt <= 8'd1) begin
          state_n     = S_CHECK;
          match_cnt_n = '0;
        end
      end
      S_CHECK: begin
        if (word_ok) begin
          if (match_cnt == MATCH_LAST) begin
            state_n  = S_LOCKED;
            locked_n = 1'b1;
            busy_n   = 1'b0;
          end else begin
            match_cnt_n = match_cnt + 8'd1;
          end
        end else begin
          state_n     = S_NEXT;
          match_cnt_n = '0;
        end
      end
      S_NEXT: begin
        if (bitslip_count < SLIP_LAST) begin
          slip_n       = bitslip_count + 4'd1;
          state_n      = S_SETTLE;
          settle_cnt_n = SETTLE_INIT;
        end else begin
          pass_cnt_n = pass_cnt + 4'd1;
          slip_n     = '0;
          if (pass_cnt + 4'd1 == PASS_LIMIT) begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n      = S_SETTLE;
            settle_cnt_n = SETTLE_INIT;
          end
        end
      end
      S_LOCKED: begin
        if (!word_ok) lock_err_n = 1'b1;
      end
      default: ;
    endcase

    // Restart overrides whatever the idle/terminal states decided above.
    if (restart) begin
      state_n      = S_SETTLE;
      slip_n       = '0;
      pass_cnt_n   = '0;
      settle_cnt_n = SETTLE_INIT;
      match_cnt_n  = '0;
      busy_n       = 1'b1;
      locked_n     = 1'b0;
      fail_n       = 1'b0;
      lock_err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_div) begin
    if (reset) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      match_cnt     <= '0;
      pass_cnt      <= '0;
      bitslip_count <= '0;
      busy          <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      lock_err      <= 1'b0;
    end else begin
      state         <= state_n;
      settle_cnt    <= settle_cnt_n;
      match_cnt     <= match_cnt_n;
      pass_cnt      <= pass_cnt_n;
      bitslip_count <= slip_n;
      busy          <= busy_n;
      locked        <= locked_n;
      fail          <= fail_n;
      lock_err      <= lock_err_n;
    end
  end

endmodule

// File: tb/tb_bitslip_train.sv
// Directed bench for bitslip_train with a 3-cycle bitslip stage model and a
// queue of expected slip counts checked whenever the DUT changes bitslip_count.
module tb_bitslip_train;

  logic       clk_div = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [7:0] frame_data;
  logic [3:0] bitslip_count;
  logic       busy, locked, fail, lock_err;

  logic [3:0] d1, d2, d3;
  logic [3:0] good;
  logic       corrupt;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];
  int         cyc;

  bitslip_train #(
    .SETTLE_CYCLES(4),
    .MATCH_CYCLES (16),
    .MAX_PASSES   (2)
  ) dut (
    .clk_div      (clk_div),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .frame_data   (frame_data),
    .bitslip_count(bitslip_count),
    .busy         (busy),
    .locked       (locked),
    .fail         (fail),
    .lock_err     (lock_err)
  );

  always #5 clk_div = ~clk_div;

  // Bitslip stage: the slip amount takes three clocks to reach the lane word.
  always @(posedge clk_div) begin
    d1 <= bitslip_count;
    d2 <= d1;
    d3 <= d2;
  end
  assign frame_data = (d3 == good && !corrupt) ? pattern : (pattern ^ 8'h5A);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(4'(i));
  endtask

  task automatic pulse_start();
    @(negedge clk_div) start = 1'b1;
    @(negedge clk_div) start = 1'b0;
    check("start_busy", busy, 1);
    check("start_slip", bitslip_count, 0);
    check("start_flags", {locked, fail, lock_err}, 0);
  endtask

  // Follows one training run until busy drops; n counts clocks after the start edge.
  task automatic watch(input int budget, input int inject_at, input int restart_at,
                       output int cycles);
    int         n;
    logic [3:0] prev;
    n    = 0;
    prev = bitslip_count;
    forever begin
      @(negedge clk_div);
      n++;
      corrupt = (n == inject_at);
      start   = (n == restart_at);
      if (bitslip_count !== prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_extra: got slip %0d expected no further change", bitslip_count);
        end else begin
          check("sb_slip", bitslip_count, exp_q.pop_front());
        end
        prev = bitslip_count;
      end
      if (!busy) break;
      if (n >= budget) begin
        total++;
        bad++;
        $error("FAIL watch_timeout: got busy after %0d cycles expected idle", n);
        break;
      end
    end
    corrupt = 1'b0;
    start   = 1'b0;
    cycles  = n;
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = 8'hF0;
    corrupt = 1'b0;
    good    = 4'd3;
    repeat (3) @(negedge clk_div);
    check("rst_slip", bitslip_count, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fail_err", {fail, lock_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_div);

    // Lock at slip 3 after visiting 0,1,2.
    good = 4'd3;
    push_range(1, 3);
    pulse_start();
    watch(300, -1, -1, cyc);
    check("lk3_cycles", cyc, 38);
    check("lk3_slip", bitslip_count, 3);
    check("lk3_locked", locked, 1);
    check("lk3_fail_err", {busy, fail, lock_err}, 0);

    // No alignment anywhere: two full sweeps then failure at 6 clocks per attempt.
    good = 4'hF;
    push_range(1, 7); exp_q.push_back(4'd0);
    push_range(1, 7); exp_q.push_back(4'd0);
    pulse_start();
    watch(300, -1, -1, cyc);
    check("fail_cycles", cyc, 96);
    check("fail_flag", fail, 1);
    check("fail_slip", bitslip_count, 0);
    check("fail_busy_lk", {busy, locked}, 0);

    // Slip 5 broken after 10 matches: continue to 6,7, wrap, relock at 5.
    good = 4'd5;
    push_range(1, 7); exp_q.push_back(4'd0); push_range(1, 5);
    pulse_start();
    watch(400, 44, -1, cyc);
    check("wrap_cycles", cyc, 108);
    check("wrap_slip", bitslip_count, 5);
    check("wrap_locked", {locked, fail}, 2'b10);

    // Corrupted word while locked at 2 sets sticky lock_err only.
    good = 4'd2;
    push_range(1, 2);
    pulse_start();
    watch(300, -1, -1, cyc);
    check("lk2_cycles", cyc, 32);
    check("lk2_err_clear", lock_err, 0);
    @(negedge clk_div) corrupt = 1'b1;
    @(negedge clk_div) corrupt = 1'b0;
    check("lkerr_set", lock_err, 1);
    check("lkerr_locked", locked, 1);
    check("lkerr_slip", bitslip_count, 2);
    repeat (3) @(negedge clk_div);
    check("lkerr_sticky", lock_err, 1);
    push_range(1, 2);
    pulse_start();
    watch(300, -1, -1, cyc);
    check("relock_slip", bitslip_count, 2);
    check("relock_flags", {locked, lock_err}, 2'b10);

    // Reset in the middle of a long CHECK at slip 4.
    good = 4'd4;
    pulse_start();
    for (int i = 0; i < 200 && bitslip_count != 4'd4; i++) @(negedge clk_div);
    check("mid_reach4", bitslip_count, 4);
    repeat (6) @(negedge clk_div);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk_div) reset = 1'b0;
    check("mid_rst_slip", bitslip_count, 0);
    check("mid_rst_flags", {busy, locked, fail, lock_err}, 0);
    repeat (3) @(negedge clk_div);
    check("mid_rst_idle", busy, 0);

    // A start pulse during slip 1 must not restart the sweep.
    good = 4'd3;
    push_range(1, 3);
    pulse_start();
    watch(300, -1, 8, cyc);
    check("nors_cycles", cyc, 38);
    check("nors_slip", {locked, bitslip_count}, 5'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
